// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
// Multi-cycle subtractor: diff = a - b - bin, computed SLICE bits per clock.
// A registered borrow ripples between slices; a start/busy/done handshake
// lets a controller sequence operands. Result outputs change only when an
// operation completes and hold until the next completion.

module nibble_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_q;
    logic [WIDTH-1:0] r_b_q;
    logic             r_borrow_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff_q;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_sum;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_last;
    logic             w_accept;

    // Current slice arithmetic: a - b - borrow as a + ~b + ~borrow with carry.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_a_sl      = r_a_q[int'(r_cnt) * SLICE +: SLICE];
        w_b_sl      = r_b_q[int'(r_cnt) * SLICE +: SLICE];
        w_sum       = {1'b0, w_a_sl} + {1'b0, ~w_b_sl} + {{SLICE{1'b0}}, ~r_borrow_q};
        w_diff_next = r_diff_q;
        w_diff_next[int'(r_cnt) * SLICE +: SLICE] = w_sum[SLICE-1:0];
        w_last      = (r_cnt == CW'(N - 1));
        w_accept    = start && (r_state != S_RUN);
    end

    // Control FSM, operand capture, slice stepping and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_borrow_q <= 1'b0;
            r_cnt      <= '0;
            r_diff_q   <= '0;
            r_diff     <= '0;
            r_bout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (r_state)
                S_RUN: begin
                    r_diff_q   <= w_diff_next;
                    r_borrow_q <= ~w_sum[SLICE];
                    r_cnt      <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_diff  <= w_diff_next;
                        r_bout  <= ~w_sum[SLICE];
                        r_ovf   <= (r_a_q[WIDTH-1] != r_b_q[WIDTH-1]) &&
                                   (w_diff_next[WIDTH-1] != r_a_q[WIDTH-1]);
                    end
                end
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state    <= S_RUN;
                        r_a_q      <= a;
                        r_b_q      <= b;
                        r_borrow_q <= bin;
                        r_cnt      <= '0;
                        r_diff_q   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Testbench for nibble_serial_subtractor: directed cases plus randomized
// operands, checked by a queue-based scoreboard against an integer model.

module tb_nibble_serial_subtractor;

    localparam int N = 4;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];

    logic [15:0] l_diff = '0;
    logic        l_bout = 1'b0;
    logic        l_ovf  = 1'b0;

    nibble_serial_subtractor dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        exp_t        e;
        int          ua, ub, sa, sb, sd;
        logic [31:0] t;
        ua = ma;
        ub = mb;
        sa = $signed(ma);
        sb = $signed(mb);
        t  = ua - ub - int'(mbin);
        sd = sa - sb - int'(mbin);
        e.diff = t[15:0];
        e.bout = (ua < ub + int'(mbin));
        e.ovf  = (sd > 32767) || (sd < -32768);
        e.due  = 0;
        return e;
    endfunction

    // Issue one operation at the first idle cycle; expectation is queued on acceptance.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ibin);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("issue_wait_idle", busy, 0);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = model(ia, ib, ibin);
        e.due = cyc + N;
        q.push_back(e);
        check("busy_after_accept", busy, 1);
    endtask

    // Monitor: pops on every done pulse; otherwise results must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_diff", diff, 0);
            check("rst_bout", bout, 0);
            check("rst_ovf", ovf, 0);
            l_diff = '0; l_bout = 1'b0; l_ovf = 1'b0;
        end else if (done) begin
            check("done_busy_low", busy, 0);
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("diff", diff, e.diff);
                check("bout", bout, e.bout);
                check("ovf", ovf, e.ovf);
                check("latency", cyc, e.due);
                l_diff = e.diff; l_bout = e.bout; l_ovf = e.ovf;
            end
        end else begin
            check("hold_diff", diff, l_diff);
            check("hold_bout", bout, l_bout);
            check("hold_ovf", ovf, l_ovf);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat[5];
        logic [15:0] ra, rb;
        int          n;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed cases
        issue(16'h000F, 16'h00F0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0);
        issue(16'h0000, 16'h0000, 1'b1);
        issue(16'h1234, 16'h0234, 1'b0);    // back-to-back: accepted in the DONE cycle

        // Start during RUN must be ignored
        issue(16'h0005, 16'h0003, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        // Reset two edges into RUN aborts the operation
        issue(16'h1234, 16'h0ABC, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_diff", diff, 0);
        #4;
        rst_n = 1'b1;
        issue(16'h7FFF, 16'hFFFF, 1'b0);
        issue(16'h8000, 16'h7FFF, 1'b1);

        // Randomized operands, biased toward boundary values
        pat[0] = 16'h0000; pat[1] = 16'hFFFF; pat[2] = 16'h8000; pat[3] = 16'h7FFF; pat[4] = 16'h0001;
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = ($urandom_range(0, 3) == 0) ? pat[$urandom_range(0, 4)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? pat[$urandom_range(0, 4)] : 16'($urandom);
            issue(ra, rb, 1'($urandom));
        end

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", q.size(), 0);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
